// File: rtl/note_sequencer.sv
// Record/playback controller between the keyboard decoder and the tone generator.
// Captures the live key stream as run-length {code, ticks} entries and replays them tick-accurately.
module note_sequencer #(
    parameter int DEPTH    = 16,
    parameter int TICK_DIV = 500000,
    parameter int DUR_W    = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [6:0]               ascii_in,
    input  logic                     key_valid,
    input  logic                     rec_start,
    input  logic                     play_start,
    input  logic                     stop,
    output logic [6:0]               note_out,
    output logic                     note_on,
    output logic                     busy_rec,
    output logic                     busy_play,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic [1:0]               state_dbg
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]    DEPTH_C   = CW'(DEPTH);
    localparam logic [PW-1:0]    TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [DUR_W-1:0] DUR_MAX   = {DUR_W{1'b1}};

    typedef enum logic [1:0] {IDLE = 2'd0, RECORD = 2'd1, PLAY = 2'd2} state_t;

    state_t            state;
    logic [PW-1:0]     presc;
    logic [6:0]        cur_code;
    logic [DUR_W-1:0]  dur;
    logic [DUR_W-1:0]  rem;
    logic [CW-1:0]     idx;
    logic [6+DUR_W:0]  mem [DEPTH];

    logic [6:0]        lc;
    logic              tick;
    logic [CW-1:0]     count_inc;
    logic [CW-1:0]     idx_inc;
    logic [DUR_W-1:0]  dur_inc;
    logic [AW-1:0]     rd_addr;
    logic [6+DUR_W:0]  rd_word;
    logic              commit_en;
    logic [6+DUR_W:0]  commit_data;

    // key_valid qualifies ascii_in each cycle; there is no back-pressure, an unqualified key reads as rest.
    assign lc        = key_valid ? ascii_in : 7'd0;
    assign tick      = (presc == TICK_LAST);
    assign count_inc = count + 1'b1;
    assign idx_inc   = idx + 1'b1;
    assign dur_inc   = dur + 1'b1;
    assign rd_addr   = (state == PLAY) ? idx_inc[AW-1:0] : '0;
    assign rd_word   = mem[rd_addr];

    assign busy_rec  = (state == RECORD);
    assign busy_play = (state == PLAY);
    assign full      = (count == DEPTH_C);
    assign state_dbg = state;

    always_comb begin
        commit_en   = 1'b0;
        commit_data = {cur_code, dur};
        if (state == RECORD) begin
            if (stop) begin
                commit_en = (dur != '0) && (count != DEPTH_C);
            end else if (lc != cur_code) begin
                commit_en = (dur != '0);
            end else if (tick && dur_inc == DUR_MAX) begin
                commit_en   = 1'b1;
                commit_data = {cur_code, DUR_MAX};
            end
        end
    end

    // Storage carries no reset; only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (commit_en) mem[count[AW-1:0]] <= commit_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            presc    <= '0;
            note_out <= '0;
            note_on  <= 1'b0;
            count    <= '0;
            cur_code <= '0;
            dur      <= '0;
            rem      <= '0;
            idx      <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            case (state)
                IDLE: begin
                    note_out <= lc;
                    note_on  <= (lc != 7'd0);
                    if (!stop && rec_start) begin
                        count    <= '0;
                        cur_code <= lc;
                        dur      <= '0;
                        presc    <= '0;
                        state    <= RECORD;
                    end else if (!stop && play_start && count != '0) begin
                        idx      <= '0;
                        note_out <= rd_word[6+DUR_W:DUR_W];
                        note_on  <= (rd_word[6+DUR_W:DUR_W] != 7'd0);
                        rem      <= rd_word[DUR_W-1:0];
                        presc    <= '0;
                        state    <= PLAY;
                    end
                end
                RECORD: begin
                    note_out <= lc;
                    note_on  <= (lc != 7'd0);
                    if (commit_en) count <= count_inc;
                    // Filling the last slot ends recording at once; the pending segment is dropped.
                    if (stop || (commit_en && count_inc == DEPTH_C)) begin
                        state <= IDLE;
                    end else if (lc != cur_code) begin
                        cur_code <= lc;
                        dur      <= '0;
                    end else if (tick) begin
                        dur <= (dur_inc == DUR_MAX) ? '0 : dur_inc;
                    end
                end
                PLAY: begin
                    if (stop) begin
                        note_out <= lc;
                        note_on  <= (lc != 7'd0);
                        state    <= IDLE;
                    end else if (tick) begin
                        if (rem <= DUR_W'(1)) begin
                            if (idx_inc < count) begin
                                idx      <= idx_inc;
                                note_out <= rd_word[6+DUR_W:DUR_W];
                                note_on  <= (rd_word[6+DUR_W:DUR_W] != 7'd0);
                                rem      <= rd_word[DUR_W-1:0];
                                presc    <= '0;
                            end else begin
                                note_out <= lc;
                                note_on  <= (lc != 7'd0);
                                state    <= IDLE;
                            end
                        end else begin
                            rem <= rem - 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: scoreboarded note stream against a run-length reference model,
// plus point checks on count/full/busy flags and asynchronous reset.
module tb_note_sequencer;
    localparam int DEPTH = 4;
    localparam int TD    = 4;
    localparam int DW    = 3;
    localparam int MAXD  = 7;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [6:0]    ascii_in = '0;
    logic          key_valid = 1'b0;
    logic          rec_start = 1'b0;
    logic          play_start = 1'b0;
    logic          stop = 1'b0;
    logic [6:0]    note_out;
    logic          note_on;
    logic          busy_rec;
    logic          busy_play;
    logic [CW-1:0] count;
    logic          full;
    logic [1:0]    state_dbg;

    always #5 clk = ~clk;

    note_sequencer #(.DEPTH(DEPTH), .TICK_DIV(TD), .DUR_W(DW)) dut (
        .clk(clk), .resetn(resetn), .ascii_in(ascii_in), .key_valid(key_valid),
        .rec_start(rec_start), .play_start(play_start), .stop(stop),
        .note_out(note_out), .note_on(note_on), .busy_rec(busy_rec), .busy_play(busy_play),
        .count(count), .full(full), .state_dbg(state_dbg)
    );

    int n_vec = 0;
    int n_miss = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    typedef enum int {M_IDLE, M_REC, M_PLAY} mode_t;
    mode_t      mode = M_IDLE;
    int         cyc = 0;
    int         play_edge = 0;
    int         play_len = 0;
    logic [6:0] trace[$];
    logic [6:0] ent_code[$];
    int         ent_dur[$];

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (resetn && exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            n_vec++;
            if ({note_on, note_out} !== mon_exp) begin
                n_miss++;
                $display("FAIL note_stream @cyc %0d: got on=%0d note=%0d, expected on=%0d note=%0d",
                         cyc, note_on, note_out, mon_exp[7], mon_exp[6:0]);
            end
        end
    end

    function automatic void push_entry(input logic [6:0] code, input int d);
        ent_code.push_back(code);
        ent_dur.push_back(d);
    endfunction

    // Run-length view of a recorded key trace: trace[0] is the key at the rec_start edge,
    // the last element the key at the stop edge; ticks land every TD edges after rec_start.
    function automatic void finalize();
        logic [6:0] code;
        int d;
        ent_code.delete();
        ent_dur.delete();
        code = trace[0];
        d = 0;
        for (int i = 1; i < trace.size(); i++) begin
            if (ent_code.size() == DEPTH) break;
            if (i == trace.size() - 1) begin
                if (d != 0) push_entry(code, d);
                break;
            end
            if (trace[i] != code) begin
                if (d != 0) push_entry(code, d);
                code = trace[i];
                d = 0;
            end else if (i % TD == 0) begin
                d++;
                if (d == MAXD) begin
                    push_entry(code, MAXD);
                    d = 0;
                end
            end
        end
    endfunction

    function automatic int total_len();
        int t = 0;
        foreach (ent_dur[j]) t += ent_dur[j] * TD;
        return t;
    endfunction

    function automatic logic [6:0] code_at(input int off);
        int o = off;
        for (int j = 0; j < ent_code.size(); j++) begin
            if (o < ent_dur[j] * TD) return ent_code[j];
            o -= ent_dur[j] * TD;
        end
        return 7'd0;
    endfunction

    task automatic set_key(input logic [6:0] code);
        if (code != 7'd0) begin
            key_valid = 1'b1;
            ascii_in  = code;
        end else if ($urandom_range(0, 1) == 1) begin
            key_valid = 1'b1;
            ascii_in  = 7'd0;
        end else begin
            key_valid = 1'b0;
            ascii_in  = 7'($urandom_range(1, 127));
        end
    endtask

    function automatic logic [6:0] rand_code();
        return ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(60, 67));
    endfunction

    // One clock: apply current inputs, advance the model, queue the expected note, clear pulses.
    task automatic step();
        logic [6:0] lc;
        logic [6:0] e;
        mode_t was;
        lc = key_valid ? ascii_in : 7'd0;
        @(posedge clk);
        cyc++;
        was = mode;
        if (stop) begin
            if (was == M_REC) begin
                trace.push_back(lc);
                finalize();
            end
            mode = M_IDLE;
        end else if (was == M_IDLE && rec_start) begin
            mode = M_REC;
            trace.delete();
            trace.push_back(lc);
            ent_code.delete();
            ent_dur.delete();
        end else if (was == M_IDLE && play_start && ent_code.size() > 0) begin
            mode = M_PLAY;
            play_edge = cyc;
            play_len = total_len();
        end else if (was == M_REC) begin
            trace.push_back(lc);
        end else if (was == M_PLAY && cyc - play_edge == play_len) begin
            mode = M_IDLE;
        end
        e = (mode == M_PLAY) ? code_at(cyc - play_edge) : lc;
        exp_q.push_back({e != 7'd0, e});
        #1;
        rec_start  = 1'b0;
        play_start = 1'b0;
        stop       = 1'b0;
    endtask

    task automatic record_seg(input logic [6:0] code, input int len);
        for (int k = 0; k < len; k++) begin
            set_key(code);
            step();
        end
    endtask

    task automatic play_all();
        int n;
        set_key(rand_code());
        play_start = 1'b1;
        step();
        n = total_len() + 2;
        for (int k = 0; k < n; k++) begin
            set_key(rand_code());
            step();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_note_out", note_out, 0);
        check("reset_note_on", note_on, 0);
        check("reset_busy_rec", busy_rec, 0);
        check("reset_busy_play", busy_play, 0);
        check("reset_count", count, 0);
        check("reset_full", full, 0);
        #3 resetn = 1'b1;

        // Pass-through
        key_valid = 1'b1; ascii_in = 7'd65;
        step();
        check("pass_note", note_out, 65);
        check("pass_on", note_on, 1);
        key_valid = 1'b0;
        step();
        check("pass_drop", note_out, 0);

        // Record 12 cycles of 65 and 8 of rest, then replay
        set_key(7'd0); rec_start = 1'b1;
        step();
        check("rec_busy", busy_rec, 1);
        record_seg(7'd65, 12);
        record_seg(7'd0, 8);
        set_key(7'd0); stop = 1'b1;
        step();
        step();
        check("rec_count", count, 2);
        check("rec_busy_after_stop", busy_rec, 0);
        set_key(7'd0); play_start = 1'b1;
        step();
        check("play_busy", busy_play, 1);
        for (int k = 0; k < 22; k++) begin
            set_key(rand_code());
            step();
        end
        check("play_done_busy", busy_play, 0);

        // Glitch filter and duration saturation
        set_key(7'd0); rec_start = 1'b1;
        step();
        record_seg(7'd66, 2);
        record_seg(7'd87, 40);
        set_key(7'd87); stop = 1'b1;
        step();
        step();
        check("sat_count", count, 2);
        check("sat_count_model", count, ent_code.size());
        play_all();

        // Fill the memory: fifth segment is discarded
        set_key(7'd0); rec_start = 1'b1;
        step();
        for (int s = 0; s < 5; s++) begin
            record_seg((s % 2 == 0) ? 7'd70 : 7'd0, 8);
            if (s == 1) check("full_busy_mid", busy_rec, 1);
        end
        check("full_busy_dropped", busy_rec, 0);
        check("full_count", count, 4);
        check("full_flag", full, 1);
        set_key(7'd0); stop = 1'b1;
        step();

        // Abort playback
        set_key(7'd0); play_start = 1'b1;
        step();
        record_seg(7'd0, 5);
        set_key(7'd72); stop = 1'b1;
        step();
        check("abort_note", note_out, 72);
        check("abort_busy", busy_play, 0);
        check("abort_count", count, 4);

        // rec_start beats play_start; then play with nothing stored
        set_key(7'd0); rec_start = 1'b1; play_start = 1'b1;
        step();
        check("prio_rec", busy_rec, 1);
        check("prio_play", busy_play, 0);
        stop = 1'b1;
        step();
        check("empty_count", count, 0);
        play_start = 1'b1;
        step();
        check("empty_play_ignored", busy_play, 0);

        // Randomized sessions
        for (int it = 0; it < 25; it++) begin
            int nseg;
            int wait_n;
            logic [6:0] c;
            c = rand_code();
            set_key(c); rec_start = 1'b1;
            step();
            nseg = $urandom_range(1, 6);
            for (int s = 0; s < nseg; s++) begin
                c = rand_code();
                record_seg(c, $urandom_range(1, 14));
            end
            set_key(c); stop = 1'b1;
            step();
            step();
            check("rand_count", count, ent_code.size());
            check("rand_full", full, (ent_code.size() == DEPTH) ? 1 : 0);
            set_key(rand_code()); play_start = 1'b1;
            step();
            wait_n = $urandom_range(1, total_len() + 4);
            record_seg(rand_code(), wait_n);
            set_key(rand_code()); stop = 1'b1;
            step();
            step();
        end

        // Asynchronous reset during playback
        set_key(7'd0); rec_start = 1'b1;
        step();
        record_seg(7'd80, 9);
        set_key(7'd0); stop = 1'b1;
        step();
        play_start = 1'b1;
        step();
        record_seg(7'd0, 3);
        #2;
        resetn = 1'b0;
        exp_q.delete();
        mode = M_IDLE;
        ent_code.delete();
        ent_dur.delete();
        #1;
        check("areset_note", note_out, 0);
        check("areset_on", note_on, 0);
        check("areset_play", busy_play, 0);
        check("areset_count", count, 0);
        repeat (2) @(posedge clk);
        #4 resetn = 1'b1;
        record_seg(7'd90, 3);
        record_seg(7'd0, 2);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d expected notes never compared, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/note_sequencer.md
# note_sequencer

Record/playback controller that sits between the keyboard decoder and the tone generator (rate divider) and decides which note code drives it. In idle and while recording it passes the live key straight through. While recording it also captures the key stream as run-length entries of {note code, duration in ticks}. On command it replays the stored entries to the tone generator with tick-accurate durations.

## Interface
Parameters:
- DEPTH, 16: number of stored entries, a power of two, max 256.
- TICK_DIV, 500000: clock cycles per duration tick (10 ms at 50 MHz).
- DUR_W, 8: duration field width. Maximum segment length is 2^DUR_W−1 ticks.

Ports:
- clk  in  1  system clock, 50 MHz.
- resetn  in  1  reset, asynchronous, active-low.
- ascii_in  in  7  live key code from the keyboard decoder.
- key_valid  in  1  high while a key is held; ascii_in is valid only when this is high.
- rec_start  in  1  one-cycle pulse that starts recording.
- play_start  in  1  one-cycle pulse that starts playback.
- stop  in  1  one-cycle pulse that ends recording or aborts playback.
- note_out  out  7  note code to the tone generator. 0 means rest.
- note_on  out  1  high when note_out is a sounding note.
- busy_rec  out  1  high in state RECORD.
- busy_play  out  1  high in state PLAY.
- count  out  clog2(DEPTH)+1  number of valid stored entries.
- full  out  1  high when count == DEPTH.

## Operation
- Live code: lc = key_valid ? ascii_in : 0.
- States: IDLE, RECORD, PLAY.
- Priority of commands: stop, then rec_start, then play_start. rec_start and play_start are ignored outside IDLE.
- Tick prescaler: counts 0..TICK_DIV−1. tick is high for one cycle when the counter equals TICK_DIV−1. The prescaler is cleared when recording is accepted and on every playback entry load.

IDLE:
- Registered pass-through: note_out <= lc, note_on <= (lc != 0).
- rec_start: count <= 0, cur_code <= lc, dur <= 0, go to RECORD.
- play_start with count > 0: load entry 0 and go to PLAY.
- play_start with count == 0: ignored.

RECORD:
- Pass-through continues exactly as in IDLE.
- If lc != cur_code:
  - if dur != 0, commit {cur_code, dur};
  - in either case set cur_code <= lc, dur <= 0.
  - A segment shorter than one tick (dur == 0) is dropped; this is the glitch filter.
- Else on tick: dur <= dur+1. If dur+1 equals the maximum, commit {cur_code, max} and set dur <= 0, keeping the same code.
- A code change and a tick in the same cycle: the change takes precedence, so the tick is not counted.
- Commit: mem[count] <= entry, count <= count+1. When count reaches DEPTH, go to IDLE immediately; the pending segment is discarded.
- stop: commit the pending segment if dur != 0 and not full, then go to IDLE.
- rec_start while already recording is ignored; the stored content is kept.

PLAY:
- Entry load: note_out <= code, note_on <= (code != 0), rem <= dur, prescaler cleared.
- On each tick: rem <= rem−1. When rem reaches 0:
  - if idx+1 < count, idx <= idx+1 and load that entry in the same cycle;
  - otherwise go to IDLE with note_out <= lc, note_on <= (lc != 0).
- Live keys are ignored during PLAY.
- stop: go to IDLE immediately; note_out and note_on take the live value on the next edge.
- Memory contents and count are preserved after playback and after an abort.

Widths:
- idx and count saturate at DEPTH; count never wraps.
- dur and rem are DUR_W bits.
- Memory is a DEPTH × (7+DUR_W) register array.

## Timing
- Reset: note_out = 0, note_on = 0, busy_rec = 0, busy_play = 0, count = 0, full = 0, state IDLE, prescaler 0. Memory contents are don't-care.
- An assertion of resetn mid-record or mid-play aborts immediately, and count returns to 0.
- Pass-through latency: 1 cycle from ascii_in/key_valid to note_out/note_on.
- Command latency: rec_start, play_start or stop sampled at edge k; state and busy flags change at edge k.
- Playback: entry 0 appears on note_out at edge k.
- Duration: each entry is held exactly dur × TICK_DIV cycles. The next entry appears on the edge where the last tick of the current entry occurs.
- Gaps: there is no gap cycle between entries. Consecutive entries with an equal code give continuous note_on.
- Quantisation: recorded durations are ±1 tick of the real hold time, because the prescaler phase is not reset at segment boundaries.
- count and full update on the cycle after a commit edge, i.e. they are registered.

## Test plan
Use TICK_DIV = 4, DEPTH = 4, DUR_W = 3 (maximum 7).
- Reset and pass-through: hold resetn = 0 → all outputs 0. Release, apply key_valid = 1 with ascii_in = 65 → note_out = 65 and note_on = 1 one cycle later. Drop key_valid → note_out = 0.
- Record and play: rec_start, then key 65 for 12 cycles, then rest for 8 cycles, then stop → count = 2, entries {65, 3} and {0, 2}. Then play_start → note_out = 65 for 12 cycles, then 0 for 8 cycles, then IDLE with busy_play = 0.
- Glitch and saturation: a 2-cycle key press during recording → no entry. Key 87 held for 40 cycles → entry {87, 7}, then the remainder {87, 3} after stop.
- Full: record 5 alternating segments of 8 cycles each → count = 4, full = 1, busy_rec drops on the 4th commit, 5th segment discarded.
- Abort and priority: stop mid-play → note_out follows the live key next cycle and count is unchanged. rec_start and play_start in the same cycle → RECORD. play_start with count = 0 → stays IDLE.
- Async reset mid-play → outputs 0 immediately without a clock edge, count = 0.
